management_tx_arbiter: RTL and testbench

MANAGEMENT_TX_ARBITER -- requirements
Module: management_tx_arbiter

---
 rtl/management_tx_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_management_tx_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/management_tx_arbiter.sv
// rtl/management_tx_arbiter.sv - two-source round-robin frame arbiter feeding the management TX path
module management_tx_arbiter #(
    parameter int IFG_CYCLES = 2,
    parameter int MAX_WORDS  = 384
) (
    input  logic        tx_clk,
    input  logic        rst_n,
    input  logic        link_up,
    input  logic        src0_frame_ready,
    input  logic [10:0] src0_frame_len,
    output logic        src0_frame_pop,
    output logic        src0_rd_en,
    input  logic [31:0] src0_rd_data,
    input  logic [2:0]  src0_rd_bytes,
    input  logic        src1_frame_ready,
    input  logic [10:0] src1_frame_len,
    output logic        src1_frame_pop,
    output logic        src1_rd_en,
    input  logic [31:0] src1_rd_data,
    input  logic [2:0]  src1_rd_bytes,
    output logic        tx_start,
    output logic        tx_data_valid,
    output logic [31:0] tx_data,
    output logic [2:0]  tx_bytes_valid,
    output logic [15:0] frames_sent,
    output logic [15:0] frames_dropped
);

    localparam logic [10:0] MAX_LEN  = 11'(MAX_WORDS);
    localparam bit          HAS_GAP  = (IFG_CYCLES > 0);
    localparam logic [15:0] GAP_LAST = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [1:0]  rst_sync_q;
    logic        rst_int_n;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic [10:0] rem_q, rem_d;
    logic [15:0] gap_q, gap_d;
    logic        discard_q, discard_d;
    logic        grant_fire;

    logic        pop0_q, pop1_q;
    logic        rd_vld_q;
    logic        rd_sel_q;
    logic        tx_start_q;
    logic        tx_start_d;
    logic        tx_valid_q;
    logic [31:0] tx_data_q;
    logic [2:0]  tx_bytes_q;
    logic [15:0] sent_q;
    logic [15:0] dropped_q;

    logic        any_ready;
    logic        pick;
    logic [10:0] pick_len;
    logic        pick_discard;
    logic        sending;

    // Reset asserts immediately but is released only after two clean clock edges.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Round-robin pick: on a tie the source not granted last wins; grant_q doubles as last-grant.
    always_comb begin
        any_ready    = src0_frame_ready | src1_frame_ready;
        pick         = (src0_frame_ready & src1_frame_ready) ? ~grant_q : src1_frame_ready;
        pick_len     = pick ? src1_frame_len : src0_frame_len;
        pick_discard = ~link_up | (pick_len == 11'd0) | (pick_len > MAX_LEN);
    end

    // Next-state logic: grant in IDLE, read len words in SEND, hold off IFG_CYCLES in GAP.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rem_d      = rem_q;
        gap_d      = gap_q;
        discard_d  = discard_q;
        grant_fire = 1'b0;
        case (state_q)
            IDLE: begin
                // A zero-length frame with no gap returns here while its pop is still
                // in flight; the length FIFO head is stale for that one cycle.
                if (any_ready && !(pop0_q || pop1_q)) begin
                    grant_fire = 1'b1;
                    grant_d    = pick;
                    rem_d      = pick_len;
                    discard_d  = pick_discard;
                    gap_d      = 16'd0;
                    if (pick_len == 11'd0) begin
                        state_d = HAS_GAP ? GAP : IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                rem_d = rem_q - 11'd1;
                if (rem_q == 11'd1) begin
                    gap_d   = 16'd0;
                    state_d = HAS_GAP ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, grant and frame bookkeeping registers.
    always_ff @(posedge tx_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= IDLE;
            grant_q   <= 1'b1;
            rem_q     <= 11'd0;
            gap_q     <= 16'd0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            discard_q <= discard_d;
        end
    end

    assign sending    = (state_q == SEND);
    assign tx_start_d = (pop0_q | pop1_q) & ~discard_q;

    // Pop pulse the cycle after grant; tx_start one cycle later for frames that will be sent.
    always_ff @(posedge tx_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pop0_q     <= 1'b0;
            pop1_q     <= 1'b0;
            tx_start_q <= 1'b0;
        end else begin
            pop0_q     <= grant_fire & ~pick;
            pop1_q     <= grant_fire & pick;
            tx_start_q <= tx_start_d;
        end
    end

    // Data path: a read issued in cycle C returns in C+1 and is registered onto tx_data for C+2.
    always_ff @(posedge tx_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rd_vld_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 32'd0;
            tx_bytes_q <= 3'd0;
        end else begin
            rd_vld_q   <= sending & ~discard_q;
            rd_sel_q   <= grant_q;
            tx_valid_q <= rd_vld_q;
            if (rd_vld_q) begin
                tx_data_q  <= rd_sel_q ? src1_rd_data : src0_rd_data;
                tx_bytes_q <= rd_sel_q ? src1_rd_bytes : src0_rd_bytes;
            end
        end
    end

    // Saturating statistics: sent counts at tx_start, dropped counts at grant of a discard frame.
    always_ff @(posedge tx_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sent_q    <= 16'd0;
            dropped_q <= 16'd0;
        end else begin
            if (tx_start_d && (sent_q != CNT_MAX)) begin
                sent_q <= sent_q + 16'd1;
            end
            if (grant_fire && pick_discard && (dropped_q != CNT_MAX)) begin
                dropped_q <= dropped_q + 16'd1;
            end
        end
    end

    assign src0_frame_pop = pop0_q;
    assign src1_frame_pop = pop1_q;
    assign src0_rd_en     = sending & ~grant_q;
    assign src1_rd_en     = sending & grant_q;
    assign tx_start       = tx_start_q;
    assign tx_data_valid  = tx_valid_q;
    assign tx_data        = tx_data_q;
    assign tx_bytes_valid = tx_bytes_q;
    assign frames_sent    = sent_q;
    assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_management_tx_arbiter.sv
// tb/tb_management_tx_arbiter.sv - scoreboard bench for management_tx_arbiter
`timescale 1ns/1ps
module tb_management_tx_arbiter;

    localparam int IFG = 2;

    typedef struct packed {
        logic [2:0]  b;
        logic [31:0] d;
    } word_t;

    logic        tx_clk = 1'b0;
    logic        rst_n;
    logic        link_up;
    logic        src0_frame_ready, src1_frame_ready;
    logic [10:0] src0_frame_len, src1_frame_len;
    logic        src0_frame_pop, src1_frame_pop;
    logic        src0_rd_en, src1_rd_en;
    logic [31:0] src0_rd_data, src1_rd_data;
    logic [2:0]  src0_rd_bytes, src1_rd_bytes;
    logic        tx_start, tx_data_valid;
    logic [31:0] tx_data;
    logic [2:0]  tx_bytes_valid;
    logic [15:0] frames_sent, frames_dropped;

    int    len_q0[$], len_q1[$];
    word_t dat_q0[$], dat_q1[$];
    word_t exp_q[$];
    word_t drv_w, mon_w;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int frame_id = 0;
    int exp_sent = 0;
    int exp_dropped = 0;
    logic [31:0] last_word;
    logic [2:0]  last_bytes;

    logic s_rd0 = 1'b0, s_rd1 = 1'b0, s_pop0 = 1'b0, s_pop1 = 1'b0;
    int pop_cnt0, pop_cnt1, pop_cyc, rd_cnt0, rd_cnt1, rd_total, first_rd, last_rd;
    int start_cnt, valid_cnt, first_valid, last_valid;
    int pop_order[$];
    int start_cycs[$];

    management_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_WORDS(384)) dut (
        .tx_clk           (tx_clk),
        .rst_n            (rst_n),
        .link_up          (link_up),
        .src0_frame_ready (src0_frame_ready),
        .src0_frame_len   (src0_frame_len),
        .src0_frame_pop   (src0_frame_pop),
        .src0_rd_en       (src0_rd_en),
        .src0_rd_data     (src0_rd_data),
        .src0_rd_bytes    (src0_rd_bytes),
        .src1_frame_ready (src1_frame_ready),
        .src1_frame_len   (src1_frame_len),
        .src1_frame_pop   (src1_frame_pop),
        .src1_rd_en       (src1_rd_en),
        .src1_rd_data     (src1_rd_data),
        .src1_rd_bytes    (src1_rd_bytes),
        .tx_start         (tx_start),
        .tx_data_valid    (tx_data_valid),
        .tx_data          (tx_data),
        .tx_bytes_valid   (tx_bytes_valid),
        .frames_sent      (frames_sent),
        .frames_dropped   (frames_dropped)
    );

    // 100 MHz clock.
    always #5 tx_clk = ~tx_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        src0_frame_ready = (len_q0.size() != 0);
        src0_frame_len   = src0_frame_ready ? 11'(len_q0[0]) : 11'd0;
        src1_frame_ready = (len_q1.size() != 0);
        src1_frame_len   = src1_frame_ready ? 11'(len_q1[0]) : 11'd0;
    endtask

    // mode: 0 = expect discard, 1 = expect transmit, 2 = cut short by reset (no expectation)
    task automatic add_frame(input int src, input int len, input int mode);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.d = {(src != 0) ? 8'hB1 : 8'hA0, 8'(frame_id), 16'(i)};
            w.b = 3'((i % 4) + 1);
            if (src != 0) dat_q1.push_back(w);
            else          dat_q0.push_back(w);
            if (mode == 1) begin
                exp_q.push_back(w);
                last_word  = w.d;
                last_bytes = w.b;
            end
        end
        if (src != 0) len_q1.push_back(len);
        else          len_q0.push_back(len);
        if (mode == 1 && exp_sent < 65535)    exp_sent++;
        if (mode == 0 && exp_dropped < 65535) exp_dropped++;
        frame_id++;
        refresh();
    endtask

    task automatic clear_stats();
        pop_cnt0 = 0; pop_cnt1 = 0; pop_cyc = -1;
        rd_cnt0 = 0; rd_cnt1 = 0; rd_total = 0; first_rd = -1; last_rd = -1;
        start_cnt = 0; valid_cnt = 0; first_valid = -1; last_valid = -1;
        pop_order.delete();
        start_cycs.delete();
    endtask

    task automatic wait_quiet(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < IFG + 6 && n < budget) begin
            @(negedge tx_clk);
            #2;
            n++;
            if (!src0_rd_en && !src1_rd_en && !src0_frame_pop && !src1_frame_pop &&
                !tx_data_valid && !tx_start && len_q0.size() == 0 && len_q1.size() == 0)
                quiet++;
            else
                quiet = 0;
        end
        check("quiet_timeout", 32'(quiet >= IFG + 6), 32'd1);
    endtask

    // Source model: data for a read seen in cycle C is presented during C+1; pops retire the head.
    always @(posedge tx_clk) begin
        cyc++;
        #1;
        if (s_rd0) begin
            drv_w = (dat_q0.size() > 0) ? dat_q0.pop_front() : '0;
            src0_rd_data  = drv_w.d;
            src0_rd_bytes = drv_w.b;
        end
        if (s_rd1) begin
            drv_w = (dat_q1.size() > 0) ? dat_q1.pop_front() : '0;
            src1_rd_data  = drv_w.d;
            src1_rd_bytes = drv_w.b;
        end
        if (s_pop0 && len_q0.size() > 0) void'(len_q0.pop_front());
        if (s_pop1 && len_q1.size() > 0) void'(len_q1.pop_front());
        refresh();
    end

    // Monitor: samples outputs mid-cycle, records event timing and scores every tx word.
    always @(negedge tx_clk) begin
        s_rd0  = src0_rd_en;
        s_rd1  = src1_rd_en;
        s_pop0 = src0_frame_pop;
        s_pop1 = src1_frame_pop;
        check("rd_en_exclusive", 32'(src0_rd_en & src1_rd_en), 32'd0);
        check("pop_exclusive", 32'(src0_frame_pop & src1_frame_pop), 32'd0);
        if (src0_frame_pop) begin pop_cnt0++; pop_cyc = cyc; pop_order.push_back(0); end
        if (src1_frame_pop) begin pop_cnt1++; pop_cyc = cyc; pop_order.push_back(1); end
        if (src0_rd_en || src1_rd_en) begin
            if (rd_total == 0) first_rd = cyc;
            last_rd = cyc;
            rd_total++;
        end
        if (src0_rd_en) rd_cnt0++;
        if (src1_rd_en) rd_cnt1++;
        if (tx_start) begin start_cnt++; start_cycs.push_back(cyc); end
        if (tx_data_valid) begin
            if (valid_cnt == 0) first_valid = cyc;
            last_valid = cyc;
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", tx_data, 32'hDEAD_0000);
            end else begin
                mon_w = exp_q.pop_front();
                check("sb_data", tx_data, mon_w.d);
                check("sb_bytes", 32'(tx_bytes_valid), 32'(mon_w.b));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_cyc;
        int p;
        int n;
        rst_n = 1'b0;
        link_up = 1'b1;
        src0_rd_data = '0; src0_rd_bytes = '0;
        src1_rd_data = '0; src1_rd_bytes = '0;
        last_word = '0; last_bytes = '0;
        clear_stats();
        refresh();

        // Reset state.
        repeat (3) @(negedge tx_clk);
        #2;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_valid", 32'(tx_data_valid), 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        check("rst_frames_dropped", 32'(frames_dropped), 32'd0);
        check("rst_pop_rd", 32'({src0_frame_pop, src1_frame_pop, src0_rd_en, src1_rd_en}), 32'd0);

        // Single frame, src0 len=3, queued while still in reset.
        add_frame(0, 3, 1);
        clear_stats();
        rel_cyc = cyc;
        rst_n = 1'b1;
        wait_quiet(200);
        p = pop_cyc;
        check("t1_pop_count", 32'(pop_cnt0), 32'd1);
        check("t1_first_grant_late_enough", 32'(p >= rel_cyc + 2), 32'd1);
        check("t1_first_rd", 32'(first_rd), 32'(p));
        check("t1_last_rd", 32'(last_rd), 32'(p + 2));
        check("t1_rd_count", 32'(rd_cnt0), 32'd3);
        check("t1_start_count", 32'(start_cnt), 32'd1);
        check("t1_start_cycle", 32'((start_cycs.size() > 0) ? start_cycs[0] : -1), 32'(p + 1));
        check("t1_first_valid", 32'(first_valid), 32'(p + 2));
        check("t1_last_valid", 32'(last_valid), 32'(p + 4));
        check("t1_frames_sent", 32'(frames_sent), 32'd1);
        check("t1_hold_data", tx_data, last_word);
        check("t1_hold_bytes", 32'(tx_bytes_valid), 32'(last_bytes));

        // Link down at grant on src1 len=4; link returns mid-frame without aborting the drop.
        clear_stats();
        link_up = 1'b0;
        add_frame(1, 4, 0);
        n = 0;
        while (pop_cnt1 == 0 && n < 50) begin @(negedge tx_clk); #2; n++; end
        link_up = 1'b1;
        wait_quiet(200);
        check("t3_rd_count", 32'(rd_cnt1), 32'd4);
        check("t3_no_valid", 32'(valid_cnt), 32'd0);
        check("t3_no_start", 32'(start_cnt), 32'd0);
        check("t3_dropped", 32'(frames_dropped), 32'(exp_dropped));

        // Following frame transmits; a link drop mid-frame does not truncate it.
        clear_stats();
        add_frame(1, 3, 1);
        n = 0;
        while (pop_cnt1 == 0 && n < 50) begin @(negedge tx_clk); #2; n++; end
        link_up = 1'b0;
        wait_quiet(200);
        link_up = 1'b1;
        check("t3b_valid_count", 32'(valid_cnt), 32'd3);
        check("t3b_start_count", 32'(start_cnt), 32'd1);
        check("t3b_frames_sent", 32'(frames_sent), 32'(exp_sent));

        // Tie: both sources hold two len=2 frames; last grant was src1.
        @(negedge tx_clk); #2;
        clear_stats();
        add_frame(0, 2, 1);
        add_frame(1, 2, 1);
        add_frame(0, 2, 1);
        add_frame(1, 2, 1);
        wait_quiet(300);
        check("t2_pop_total", 32'(pop_order.size()), 32'd4);
        if (pop_order.size() == 4) begin
            check("t2_grant0", 32'(pop_order[0]), 32'd0);
            check("t2_grant1", 32'(pop_order[1]), 32'd1);
            check("t2_grant2", 32'(pop_order[2]), 32'd0);
            check("t2_grant3", 32'(pop_order[3]), 32'd1);
        end
        check("t2_start_count", 32'(start_cycs.size()), 32'd4);
        if (start_cycs.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("t2_start_spacing", 32'(start_cycs[i] - start_cycs[i-1]), 32'(2 + IFG + 1));
        end
        check("t2_frames_sent", 32'(frames_sent), 32'(exp_sent));

        // Asynchronous reset during word 2 of a 5-word frame.
        clear_stats();
        add_frame(0, 5, 2);
        n = 0;
        while (rd_cnt0 < 2 && n < 50) begin @(negedge tx_clk); #2; n++; end
        check("t4_reached_word2", 32'(rd_cnt0), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t4_tx_start", 32'(tx_start), 32'd0);
        check("t4_tx_valid", 32'(tx_data_valid), 32'd0);
        check("t4_tx_data", tx_data, 32'd0);
        check("t4_tx_bytes", 32'(tx_bytes_valid), 32'd0);
        check("t4_rd_pop", 32'({src0_rd_en, src1_rd_en, src0_frame_pop, src1_frame_pop}), 32'd0);
        check("t4_frames_sent", 32'(frames_sent), 32'd0);
        check("t4_frames_dropped", 32'(frames_dropped), 32'd0);
        len_q0.delete(); len_q1.delete();
        dat_q0.delete(); dat_q1.delete();
        exp_q.delete();
        exp_sent = 0;
        exp_dropped = 0;
        refresh();
        repeat (2) @(negedge tx_clk);
        #2;
        add_frame(0, 1, 1);
        add_frame(1, 1, 1);
        clear_stats();
        rst_n = 1'b1;
        wait_quiet(200);
        check("t4_pop_total", 32'(pop_order.size()), 32'd2);
        if (pop_order.size() == 2) begin
            check("t4_first_tie_src0", 32'(pop_order[0]), 32'd0);
            check("t4_second_src1", 32'(pop_order[1]), 32'd1);
        end
        check("t4_frames_sent_after", 32'(frames_sent), 32'(exp_sent));

        // Illegal lengths: zero, then MAX_WORDS+1; then exactly MAX_WORDS is legal.
        clear_stats();
        add_frame(0, 0, 0);
        wait_quiet(100);
        check("t5_len0_pop", 32'(pop_cnt0), 32'd1);
        check("t5_len0_no_rd", 32'(rd_total), 32'd0);
        check("t5_len0_dropped", 32'(frames_dropped), 32'd1);
        add_frame(1, 385, 0);
        wait_quiet(1000);
        check("t5_len385_rd", 32'(rd_cnt1), 32'd385);
        check("t5_len385_no_valid", 32'(valid_cnt), 32'd0);
        check("t5_len385_no_start", 32'(start_cnt), 32'd0);
        check("t5_len385_dropped", 32'(frames_dropped), 32'd2);
        add_frame(0, 384, 1);
        wait_quiet(1000);
        check("t5_len384_rd", 32'(rd_cnt0), 32'd384);
        check("t5_len384_valid", 32'(valid_cnt), 32'd384);
        check("t5_len384_sent", 32'(frames_sent), 32'(exp_sent));

        // Counter saturation: preload frames_sent to all-ones, send one more frame.
        @(negedge tx_clk); #2;
        force dut.sent_q = 16'hFFFF;
        @(negedge tx_clk); #2;
        release dut.sent_q;
        @(negedge tx_clk); #2;
        check("t6_preload", 32'(frames_sent), 32'h0000_FFFF);
        exp_sent = 65535;
        clear_stats();
        add_frame(0, 2, 1);
        wait_quiet(200);
        check("t6_valid_count", 32'(valid_cnt), 32'd2);
        check("t6_saturated", 32'(frames_sent), 32'h0000_FFFF);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
